// File: rtl/truth_table_pkg.sv
// rtl/truth_table_pkg.sv - shared types and helpers for the truth-table characterizer
package truth_table_pkg;

  localparam int MAX_N_IN = 4;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    DONE
  } state_t;

  function automatic int code_width(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/truth_table_extractor_settle_timer.sv
// rtl/truth_table_extractor_settle_timer.sv - hold counter with terminal flag and sample-change detect
module settle_timer #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic enable,
  input  logic sample,
  output logic terminal,
  output logic changed
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES - 1);

  logic [CW-1:0] count;
  logic          prev;

  // prev tracks the sample every cycle so the compare always sees the immediately preceding value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      prev  <= 1'b0;
    end else begin
      prev <= sample;
      if (load)
        count <= '0;
      else if (enable)
        count <= count + CW'(1);
    end
  end

  assign terminal = enable && (count == LAST);
  assign changed  = (sample != prev);

endmodule

// File: rtl/truth_table_extractor.sv
// rtl/truth_table_extractor.sv - sweeps all gate input vectors and rebuilds the truth-table code
module truth_table_extractor
  import truth_table_pkg::*;
#(
  parameter int N_IN          = 3,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  output logic [N_IN-1:0]              drive_in,
  input  logic                         sample_out,
  output logic                         busy,
  output logic                         done,
  output logic [code_width(N_IN)-1:0]  code,
  output logic                         code_valid,
  output logic                         unstable
);

  localparam int W = code_width(N_IN);

  if (N_IN < 1 || N_IN > MAX_N_IN) begin : g_bad_n_in
    $error("truth_table_extractor: N_IN out of range");
  end
  if (SETTLE_CYCLES < 2) begin : g_bad_settle
    $error("truth_table_extractor: SETTLE_CYCLES below 2");
  end

  state_t          state, state_next;
  logic [N_IN-1:0] vec;
  logic [W-1:0]    sr;
  logic [W-1:0]    sr_shifted;
  logic            sticky;
  logic            accept, hold, terminal, changed, last_vec;

  settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept || terminal),
    .enable   (hold),
    .sample   (sample_out),
    .terminal (terminal),
    .changed  (changed)
  );

  assign hold       = (state == HOLD);
  assign last_vec   = &vec;
  assign sr_shifted = {sr[W-2:0], sample_out};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept     = 1'b1;
        state_next = HOLD;
      end
      HOLD: if (terminal && last_vec) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Results are loaded on the edge entering DONE so they change together with done rising
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec        <= '0;
      sr         <= '0;
      sticky     <= 1'b0;
      code       <= '0;
      code_valid <= 1'b0;
      unstable   <= 1'b0;
    end else begin
      if (accept) begin
        vec        <= '0;
        sticky     <= 1'b0;
        code_valid <= 1'b0;
      end
      if (terminal) begin
        sr     <= sr_shifted;
        sticky <= sticky | changed;
        if (!last_vec) begin
          vec <= vec + N_IN'(1);
        end else begin
          code       <= sr_shifted;
          code_valid <= 1'b1;
          unstable   <= sticky | changed;
        end
      end
    end
  end

  assign drive_in = hold ? vec : '0;
  assign busy     = hold;
  assign done     = (state == DONE);

endmodule
